fsm_stim_driver: RTL and testbench

- Stimulus source and response compactor for the keyed controller benchmarks.
- Drives the 12-bit primary-input vector and the key bit into a controller under test, one stored vector per cycle.
- Folds the controller's 32-bit output word into a MISR each cycle, then compares the final signature against an expected value.
- Used on-chip and in benches to tell a correct key (signature match) from a wrong key or a counter-triggered payload (mismatch).

---
 rtl/fsm_stim_driver.sv | 184 ++++++++++++++++++
 tb/tb_fsm_stim_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stim_driver.sv
// Stimulus source and MISR response compactor for keyed controller runs.
// Optional pass/fail run counters: define FSM_STIM_DRV_RUN_CNT_EN.
module fsm_stim_driver #(
  parameter int                NUM_VEC     = 16,
  parameter int                VEC_W       = 12,
  parameter int                RESP_W      = 32,
  parameter logic [RESP_W-1:0] SIG_SEED    = 32'hFFFF_FFFF,
  parameter int                DUT_RST_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(NUM_VEC)-1:0] load_addr,
  input  logic [VEC_W-1:0]           load_data,
  input  logic [$clog2(NUM_VEC):0]   vec_count,
  input  logic                       key_in,
  input  logic [RESP_W-1:0]          exp_sig,
  input  logic                       start,
  output logic [VEC_W-1:0]           x_out,
  output logic                       key_out,
  output logic                       dut_rst,
  input  logic [RESP_W-1:0]          resp_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [RESP_W-1:0]          sig_out
`ifdef FSM_STIM_DRV_RUN_CNT_EN
  ,
  output logic [15:0]                pass_cnt,
  output logic [15:0]                fail_cnt
`endif
);

  localparam int AW = $clog2(NUM_VEC);
  localparam int CW = AW + 1;
  localparam int RW = (DUT_RST_CYC > 1) ? $clog2(DUT_RST_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRST,
    DRIVE,
    CMP
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       vcnt_q, vcnt_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic                key_q, key_d;
  logic [RESP_W-1:0]   exp_q, exp_d;
  logic [RESP_W-1:0]   sig_q, sig_d;
  logic                pass_q, pass_d;
  logic [VEC_W-1:0]    mem_q [NUM_VEC];

  logic [CW-1:0]       vc_clamp;
  logic                last_vec;
  logic                fb;
  logic [RESP_W-1:0]   misr;

  assign vc_clamp = (vec_count > CW'(NUM_VEC)) ? CW'(NUM_VEC) : vec_count;
  assign last_vec = ({1'b0, idx_q} == (vcnt_q - CW'(1)));
  // x^32 + x^22 + x^2 + x + 1
  assign fb       = sig_q[RESP_W-1] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];
  assign misr     = {sig_q[RESP_W-2:0], fb} ^ resp_in;

  assign busy    = (state_q != IDLE);
  assign pass    = pass_q;
  assign sig_out = sig_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vcnt_d  = vcnt_q;
    rcnt_d  = rcnt_q;
    key_d   = key_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    x_out   = '0;
    key_out = 1'b0;
    dut_rst = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vcnt_d  = vc_clamp;
          key_d   = key_in;
          exp_d   = exp_sig;
          sig_d   = SIG_SEED;
          pass_d  = 1'b0;
          rcnt_d  = '0;
          state_d = DRST;
        end
      end
      DRST: begin
        dut_rst = 1'b1;
        key_out = key_q;
        if (rcnt_q == RW'(DUT_RST_CYC - 1)) begin
          idx_d   = '0;
          state_d = (vcnt_q == '0) ? CMP : DRIVE;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      DRIVE: begin
        x_out   = mem_q[idx_q];
        key_out = key_q;
        sig_d   = misr;
        if (last_vec) begin
          state_d = CMP;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      CMP: begin
        key_out = key_q;
        done    = 1'b1;
        pass_d  = (sig_q == exp_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vcnt_q  <= '0;
      rcnt_q  <= '0;
      key_q   <= 1'b0;
      exp_q   <= '0;
      sig_q   <= SIG_SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vcnt_q  <= vcnt_d;
      rcnt_q  <= rcnt_d;
      key_q   <= key_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  // Writes land only while idle, so a run never sees its vectors change.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == IDLE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifdef FSM_STIM_DRV_RUN_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (state_q == CMP) begin
      if (sig_q == exp_q) begin
        if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
      end else begin
        if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign pass_cnt = pcnt_q;
  assign fail_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed bench for fsm_stim_driver: scoreboard of expected run results
// checked by a monitor on each done pulse, plus inline per-cycle checks.
module tb_fsm_stim_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic [4:0]  vec_count;
  logic        key_in;
  logic [31:0] exp_sig;
  logic        start;
  logic [11:0] x_out;
  logic        key_out;
  logic        dut_rst;
  logic [31:0] resp_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] sig_out;
`ifdef FSM_STIM_DRV_RUN_CNT_EN
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  int          pcnt_m = 0;
  int          fcnt_m = 0;
`endif

  fsm_stim_driver dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .vec_count (vec_count),
    .key_in    (key_in),
    .exp_sig   (exp_sig),
    .start     (start),
    .x_out     (x_out),
    .key_out   (key_out),
    .dut_rst   (dut_rst),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sig_out   (sig_out)
`ifdef FSM_STIM_DRV_RUN_CNT_EN
    ,
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dcyc;
    logic [31:0] sig;
    logic        pass;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mem_m [16];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          @(negedge clk);
          chk("pass", 32'(pass), 32'(e.pass));
          chk("sig_out", sig_out, e.sig);
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    mem_m[a]  = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_run(input int vc, input logic key,
                        input logic [31:0] ex, input logic [31:0] rsp,
                        input logic [31:0] esig, input logic epass,
                        input bit disturb, input bit wr,
                        input logic [3:0] wa, input logic [11:0] wd,
                        input int abort_j);
    int   eff;
    exp_t e;
    eff = (vc > 16) ? 16 : vc;
    @(negedge clk);
    if (wr) begin
      load_en   = 1'b1;
      load_addr = wa;
      load_data = wd;
      mem_m[wa] = wd;
    end
    start     = 1'b1;
    vec_count = 5'(vc);
    key_in    = key;
    exp_sig   = ex;
    resp_in   = rsp;
    if (abort_j < 0) begin
      e.dcyc = cyc + 3 + eff;
      e.sig  = esig;
      e.pass = epass;
      sb.push_back(e);
`ifdef FSM_STIM_DRV_RUN_CNT_EN
      if (epass) pcnt_m++;
      else fcnt_m++;
`endif
    end
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    key_in  = ~key;
    for (int k = 0; k < 2; k++) begin
      chk("drst_dut_rst", 32'(dut_rst), 32'd1);
      chk("drst_x_out", 32'(x_out), 32'd0);
      chk("drst_key", 32'(key_out), 32'(key));
      chk("drst_busy", 32'(busy), 32'd1);
      if (k == 0 && disturb) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 12'h123;
      end
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
    end
    for (int j = 0; j < eff; j++) begin
      if (j == abort_j) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dut_rst", 32'(dut_rst), 32'd0);
        chk("abort_x_out", 32'(x_out), 32'd0);
        chk("abort_sig", sig_out, 32'hFFFF_FFFF);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
`ifdef FSM_STIM_DRV_RUN_CNT_EN
        pcnt_m = 0;
        fcnt_m = 0;
        chk("abort_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
`endif
        rst = 1'b0;
        return;
      end
      chk("drive_x_out", 32'(x_out), 32'(mem_m[j]));
      chk("drive_key", 32'(key_out), 32'(key));
      chk("drive_dut_rst", 32'(dut_rst), 32'd0);
      @(negedge clk);
    end
    chk("cmp_x_out", 32'(x_out), 32'd0);
    chk("cmp_dut_rst", 32'(dut_rst), 32'd0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
`ifdef FSM_STIM_DRV_RUN_CNT_EN
    chk("pass_cnt", 32'(pass_cnt), 32'(pcnt_m));
    chk("fail_cnt", 32'(fail_cnt), 32'(fcnt_m));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    vec_count = '0;
    key_in    = 1'b0;
    exp_sig   = '0;
    start     = 1'b0;
    resp_in   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_dut_rst", 32'(dut_rst), 32'd0);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_sig", sig_out, 32'hFFFF_FFFF);
`ifdef FSM_STIM_DRV_RUN_CNT_EN
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
`endif

    load(4'd0, 12'h842);
    load(4'd1, 12'h084);
    load(4'd2, 12'h000);
    load(4'd3, 12'hFFF);
    for (int i = 4; i < 16; i++) begin
      load(4'(i), 12'(i * 12'h135) ^ 12'hA5A);
    end

    // vc, key, exp_sig, resp, exp sig_out, exp pass, disturb, wr, wa, wd, abort
    do_run(1, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 1'b1,
           0, 0, 4'd0, 12'h0, -1);
    do_run(1, 1'b0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 1'b0,
           0, 0, 4'd0, 12'h0, -1);
    do_run(4, 1'b1, 32'hFFFF_FFF6, 32'h0, 32'hFFFF_FFF6, 1'b1,
           0, 0, 4'd0, 12'h0, -1);
    do_run(0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1,
           0, 0, 4'd0, 12'h0, -1);
    do_run(4, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF6, 1'b0,
           1, 0, 4'd0, 12'h0, -1);
    do_run(1, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 1'b1,
           0, 0, 4'd0, 12'h0, -1);
    do_run(2, 1'b0, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFFD, 1'b1,
           0, 1, 4'd1, 12'h5A5, -1);
    do_run(20, 1'b1, 32'hFFFF_6DB6, 32'h0, 32'hFFFF_6DB6, 1'b1,
           0, 0, 4'd0, 12'h0, -1);
    do_run(4, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0,
           0, 0, 4'd0, 12'h0, 2);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
